// File: rtl/pulse_prescaler.sv
// pulse_prescaler: modulo-N tick counter for clock/timer chains.
//
// Counts qualifying tick_in strobes (tick_in & run) or manual inc_in strobes,
// wraps at mod_q, and emits a registered one-cycle carry (tick_out) only on
// wraps caused by a run-qualified tick_in. The modulus is loadable at runtime
// and clamped to a minimum of 2.
//
// Optional feature macro: PRESCALER_SQUARE_OUT_EN adds a registered
// square_out that toggles on every carry (50% duty, period 2*mod_q ticks).
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   tick_in    in   one-cycle count strobe from upstream
//   run        in   1 = tick_in counted, 0 = ignored
//   inc_in     in   one-cycle manual increment (never carries)
//   clr        in   synchronous clear of count
//   mod_wr     in   load strobe for mod_val
//   mod_val    in   new modulus (0 and 1 load as 2)
//   count      out  registered current count
//   mod_q      out  registered active modulus
//   tick_out   out  registered one-cycle carry pulse
//   square_out out  (macro only) registered divided square wave
module pulse_prescaler #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned MOD_DEFAULT = 60
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_in,
  input  logic             run,
  input  logic             inc_in,
  input  logic             clr,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] mod_q,
`ifdef PRESCALER_SQUARE_OUT_EN
  output logic             tick_out,
  output logic             square_out
`else
  output logic             tick_out
`endif
);

  localparam logic [WIDTH-1:0] ModMin = WIDTH'(2);
  localparam logic [WIDTH-1:0] ModRst = (MOD_DEFAULT < 2) ? ModMin : WIDTH'(MOD_DEFAULT);

  logic [WIDTH-1:0] r_count, r_count_d;
  logic [WIDTH-1:0] r_mod_q, r_mod_q_d;
  logic             r_tick, r_tick_d;

  logic             w_qual;
  logic             w_adv;
  logic             w_wrap;
  logic [WIDTH-1:0] w_mod_new;

  // Only run-qualified ticks may carry; inc_in advances but never carries.
  assign w_qual    = tick_in & run;
  assign w_adv     = w_qual | inc_in;
  // mod_q >= 2 always, so mod_q - 1 cannot underflow.
  assign w_wrap    = (r_count >= (r_mod_q - 1'b1));
  assign w_mod_new = (mod_val < ModMin) ? ModMin : mod_val;

  always_comb begin
    r_count_d = r_count;
    r_mod_q_d = r_mod_q;
    r_tick_d  = 1'b0;
    if (clr) begin
      r_count_d = '0;
    end else if (mod_wr) begin
      r_mod_q_d = w_mod_new;
      // Keep count inside the new range.
      if (r_count >= (w_mod_new - 1'b1)) begin
        r_count_d = '0;
      end
    end else if (w_adv) begin
      if (w_wrap) begin
        r_count_d = '0;
        r_tick_d  = w_qual;
      end else begin
        r_count_d = r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_mod_q <= ModRst;
      r_tick  <= 1'b0;
    end else begin
      r_count <= r_count_d;
      r_mod_q <= r_mod_q_d;
      r_tick  <= r_tick_d;
    end
  end

  assign count    = r_count;
  assign mod_q    = r_mod_q;
  assign tick_out = r_tick;

`ifdef PRESCALER_SQUARE_OUT_EN
  logic r_square;

  // Toggles on exactly the events that raise tick_out; clr does not touch it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_square <= 1'b0;
    end else if (r_tick_d) begin
      r_square <= ~r_square;
    end
  end

  assign square_out = r_square;
`endif

endmodule
